dmac_burst_ctrl: RTL and testbench
==================================

Name: dmac_burst_ctrl

Overview:
- Single-channel DMA burst sequencer: copies byte_len_i bytes from src_addr_i to dst_addr_i.
- Issues AXI-style read bursts that fill the DMAC FIFO, then write bursts that drain it.
- Sits between the DMAC config registers, the AXI master ports and the DMAC FIFO (depth 2^4, 32-bit). One burst in flight at a time; the FIFO is the only data buffer.

Parameters:
- ADDR_WIDTH, 32, address width of src/dst and AR/AW channels
- DATA_WIDTH, 32, beat width; must equal the FIFO DATA_WIDTH
- LEN_WIDTH, 16, width of byte_len_i
- MAX_BEATS_LG2, 4, log2 of maximum beats per burst; must be ≤ the FIFO DEPTH_LG2

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle start pulse, sampled only in IDLE
- src_addr_i  in  ADDR_WIDTH  source byte address, word aligned
- dst_addr_i  in  ADDR_WIDTH  destination byte address, word aligned
- byte_len_i  in  LEN_WIDTH  transfer length in bytes; bits [1:0] ignored
- busy_o  out  1  high from accepted start until done
- done_o  out  1  one-cycle pulse when the transfer completes
- araddr_o / arlen_o / arvalid_o  out  ADDR_WIDTH / 4 / 1  read address channel (arlen = beats-1)
- arready_i  in  1  read address ready
- rdata_i / rlast_i / rvalid_i  in  DATA_WIDTH / 1 / 1  read data channel
- rready_o  out  1  read data ready
- awaddr_o / awlen_o / awvalid_o  out  ADDR_WIDTH / 4 / 1  write address channel
- awready_i  in  1  write address ready
- wdata_o / wlast_o / wvalid_o  out  DATA_WIDTH / 1 / 1  write data channel
- wready_i  in  1  write data ready
- bvalid_i  in  1  write response valid (resp ignored)
- bready_o  out  1  write response ready
- fifo_wren_o / fifo_wdata_o  out  1 / DATA_WIDTH  FIFO push
- fifo_full_i  in  1  FIFO full
- fifo_rden_o  out  1  FIFO pop
- fifo_rdata_i  in  DATA_WIDTH  FIFO head data (valid whenever not empty)
- fifo_empty_i  in  1  FIFO empty

Behaviour:
- Reset (async assert, sync deassert in system): state IDLE; busy_o, done_o, all valid/ready outputs, and fifo_wren_o/fifo_rden_o = 0; addresses, length and counters = 0.
- Registered state: src, dst, remaining words, burst beats, beat counter.
- States: IDLE, RREQ, RDATA, WREQ, WDATA, WRESP.
- IDLE: on start_i, latch src, dst and words = byte_len_i >> 2. If words == 0, pulse done_o next cycle and stay in IDLE (busy_o stays 0). Otherwise go to RREQ with busy_o = 1. Starts while busy are ignored.
- Burst beats = min(words, 2^MAX_BEATS_LG2). This value is computed on entry to RREQ and held for the read and write of the same burst.
- RREQ: arvalid_o = 1, araddr_o = src, arlen_o = beats-1. Outputs are held stable until arready_i. On handshake go to RDATA.
- RDATA: rready_o = ~fifo_full_i. fifo_wren_o = rvalid_i & rready_o, fifo_wdata_o = rdata_i. Count beats. On the accepted beat with rlast_i, go to WREQ and add beats*4 to src. rlast_i is trusted; beat count is for checking only.
- WREQ: awvalid_o = 1, awaddr_o = dst, awlen_o = beats-1, held until awready_i. Then go to WDATA.
- WDATA: wvalid_o = ~fifo_empty_i, wdata_o = fifo_rdata_i (combinational). fifo_rden_o = wvalid_o & wready_i. wlast_o = 1 when beat counter == beats-1. After the last handshake go to WRESP and add beats*4 to dst.
- WRESP: bready_o = 1. On bvalid_i, words -= beats. If words == 0, return to IDLE with done_o pulsed for one cycle and busy_o cleared in the same cycle. Otherwise go back to RREQ.
- Bursts never exceed FIFO capacity, so the FIFO is never full at a burst start. Overflow/underflow is impossible by construction: every push is gated by ~full, every pop by ~empty.
- No 4 KB boundary splitting; software guarantees no burst crosses one. Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Reset mid-transfer: immediate abort to IDLE, no done_o pulse. The FIFO is reset by the same system reset.

Decomposition:
- Shared package dmac_pkg holds the state enum (dmac_burst_state_t), BEAT_BYTES = DATA_WIDTH/8, and the AXI len width constant (4).
- Natural sub-module: dmac_burst_calc, combinational min(words, max_beats) plus the address increment.

Test Plan:
- Reset then idle: all outputs 0 and no valids for 20 cycles; start with byte_len=0 → done_o pulse within 2 cycles, no AR issued.
- Single burst: src=0x1000, dst=0x2000, len=64 → one AR (0x1000, arlen=15), 16 FIFO pushes, one AW (0x2000, awlen=15), wlast on beat 16, done_o after B.
- Multi-burst: len=200 (50 words) → bursts of 16,16,16,2; araddr 0x1000,0x1040,0x1080,0x10C0; awlen 15,15,15,1; write data equals read data in order.
- Backpressure: random arready/awready/wready/rvalid/bvalid stalls, len=128 → address outputs stable while valid is high, no lost or duplicated data, done_o exactly once.
- Start while busy: second start_i mid-transfer ignored; busy_o stays high and only one done_o pulse.
- Async reset in WDATA after 5 beats → outputs 0 immediately, state IDLE; a new start with len=16 completes correctly.

Source files
------------

// File: rtl/dmac_pkg.sv
// rtl/dmac_pkg.sv - shared state type and constants for the DMA burst sequencer
package dmac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RREQ,
        ST_RDATA,
        ST_WREQ,
        ST_WDATA,
        ST_WRESP
    } dmac_burst_state_t;

    localparam int DMAC_DATA_WIDTH = 32;
    localparam int BEAT_BYTES      = DMAC_DATA_WIDTH / 8;
    localparam int AXI_LEN_WIDTH   = 4;

endpackage

// File: rtl/dmac_burst_calc.sv
// rtl/dmac_burst_calc.sv - burst size clamp and post-burst address increment
module dmac_burst_calc
    import dmac_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int LEN_WIDTH     = 16,
    parameter int MAX_BEATS_LG2 = 4
) (
    input  logic [LEN_WIDTH-1:0]     i_words,
    input  logic [MAX_BEATS_LG2:0]   i_beats,
    input  logic [ADDR_WIDTH-1:0]    i_src,
    input  logic [ADDR_WIDTH-1:0]    i_dst,
    output logic [MAX_BEATS_LG2:0]   o_beats,
    output logic [ADDR_WIDTH-1:0]    o_src_next,
    output logic [ADDR_WIDTH-1:0]    o_dst_next
);

    localparam logic [LEN_WIDTH-1:0]     MAX_WORDS = LEN_WIDTH'(1 << MAX_BEATS_LG2);
    localparam logic [MAX_BEATS_LG2:0]   MAX_BEATS = (MAX_BEATS_LG2 + 1)'(1 << MAX_BEATS_LG2);

    logic [ADDR_WIDTH-1:0] w_step;

    assign o_beats    = (i_words > MAX_WORDS) ? MAX_BEATS : i_words[MAX_BEATS_LG2:0];
    // Address sums wrap naturally at ADDR_WIDTH bits.
    assign w_step     = ADDR_WIDTH'(i_beats) * ADDR_WIDTH'(BEAT_BYTES);
    assign o_src_next = i_src + w_step;
    assign o_dst_next = i_dst + w_step;

endmodule

// File: rtl/dmac_burst_ctrl.sv
// rtl/dmac_burst_ctrl.sv - single-channel DMA sequencer: read bursts fill the FIFO, write bursts drain it
module dmac_burst_ctrl
    import dmac_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int LEN_WIDTH     = 16,
    parameter int MAX_BEATS_LG2 = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [ADDR_WIDTH-1:0]    src_addr_i,
    input  logic [ADDR_WIDTH-1:0]    dst_addr_i,
    input  logic [LEN_WIDTH-1:0]     byte_len_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [ADDR_WIDTH-1:0]    araddr_o,
    output logic [AXI_LEN_WIDTH-1:0] arlen_o,
    output logic                     arvalid_o,
    input  logic                     arready_i,
    input  logic [DATA_WIDTH-1:0]    rdata_i,
    input  logic                     rlast_i,
    input  logic                     rvalid_i,
    output logic                     rready_o,
    output logic [ADDR_WIDTH-1:0]    awaddr_o,
    output logic [AXI_LEN_WIDTH-1:0] awlen_o,
    output logic                     awvalid_o,
    input  logic                     awready_i,
    output logic [DATA_WIDTH-1:0]    wdata_o,
    output logic                     wlast_o,
    output logic                     wvalid_o,
    input  logic                     wready_i,
    input  logic                     bvalid_i,
    output logic                     bready_o,
    output logic                     fifo_wren_o,
    output logic [DATA_WIDTH-1:0]    fifo_wdata_o,
    input  logic                     fifo_full_i,
    output logic                     fifo_rden_o,
    input  logic [DATA_WIDTH-1:0]    fifo_rdata_i,
    input  logic                     fifo_empty_i
);

    localparam int                 BW       = MAX_BEATS_LG2 + 1;
    localparam logic [BW-1:0]      ONE_BEAT = BW'(1);

    dmac_burst_state_t     r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_src, r_dst;
    logic [LEN_WIDTH-1:0]  r_words;
    logic [BW-1:0]         r_beats, r_cnt;
    logic                  r_done;

    logic [LEN_WIDTH-1:0]     w_words_left, w_calc_words;
    logic [BW-1:0]            w_calc_beats, w_last_idx;
    logic [ADDR_WIDTH-1:0]    w_src_next, w_dst_next;
    logic [AXI_LEN_WIDTH-1:0] w_axi_len;
    logic                     w_rbeat, w_wbeat;

    assign w_words_left = r_words - LEN_WIDTH'(r_beats);
    // In IDLE the clamp sizes the first burst from the request, in WRESP the next one.
    assign w_calc_words = (r_state == ST_IDLE) ? (byte_len_i >> 2) : w_words_left;
    assign w_last_idx   = r_beats - ONE_BEAT;
    assign w_axi_len    = AXI_LEN_WIDTH'(w_last_idx);

    dmac_burst_calc #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .LEN_WIDTH     (LEN_WIDTH),
        .MAX_BEATS_LG2 (MAX_BEATS_LG2)
    ) u_calc (
        .i_words    (w_calc_words),
        .i_beats    (r_beats),
        .i_src      (r_src),
        .i_dst      (r_dst),
        .o_beats    (w_calc_beats),
        .o_src_next (w_src_next),
        .o_dst_next (w_dst_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        arvalid_o    = 1'b0;
        araddr_o     = '0;
        arlen_o      = '0;
        rready_o     = 1'b0;
        fifo_wren_o  = 1'b0;
        fifo_wdata_o = '0;
        awvalid_o    = 1'b0;
        awaddr_o     = '0;
        awlen_o      = '0;
        wvalid_o     = 1'b0;
        wdata_o      = '0;
        wlast_o      = 1'b0;
        fifo_rden_o  = 1'b0;
        bready_o     = 1'b0;
        w_rbeat      = 1'b0;
        w_wbeat      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i && (w_calc_words != '0)) w_next = ST_RREQ;
            end
            ST_RREQ: begin
                arvalid_o = 1'b1;
                araddr_o  = r_src;
                arlen_o   = w_axi_len;
                if (arready_i) w_next = ST_RDATA;
            end
            ST_RDATA: begin
                rready_o     = ~fifo_full_i;
                w_rbeat      = rvalid_i & ~fifo_full_i;
                fifo_wren_o  = w_rbeat;
                fifo_wdata_o = rdata_i;
                if (w_rbeat && rlast_i) w_next = ST_WREQ;
            end
            ST_WREQ: begin
                awvalid_o = 1'b1;
                awaddr_o  = r_dst;
                awlen_o   = w_axi_len;
                if (awready_i) w_next = ST_WDATA;
            end
            ST_WDATA: begin
                wvalid_o    = ~fifo_empty_i;
                wdata_o     = fifo_rdata_i;
                wlast_o     = (r_cnt == w_last_idx);
                w_wbeat     = ~fifo_empty_i & wready_i;
                fifo_rden_o = w_wbeat;
                if (w_wbeat && wlast_o) w_next = ST_WRESP;
            end
            ST_WRESP: begin
                bready_o = 1'b1;
                if (bvalid_i) w_next = (w_words_left == '0) ? ST_IDLE : ST_RREQ;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_words <= '0;
            r_beats <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_src   <= src_addr_i;
                        r_dst   <= dst_addr_i;
                        r_words <= w_calc_words;
                        r_beats <= w_calc_beats;
                        r_cnt   <= '0;
                        if (w_calc_words == '0) r_done <= 1'b1;
                    end
                end
                ST_RDATA: begin
                    if (w_rbeat) begin
                        if (rlast_i) begin
                            r_src <= w_src_next;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + ONE_BEAT;
                        end
                    end
                end
                ST_WDATA: begin
                    if (w_wbeat) begin
                        if (wlast_o) begin
                            r_dst <= w_dst_next;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + ONE_BEAT;
                        end
                    end
                end
                ST_WRESP: begin
                    if (bvalid_i) begin
                        r_words <= w_words_left;
                        r_beats <= w_calc_beats;
                        if (w_words_left == '0) r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (r_state != ST_IDLE);
    assign done_o = r_done;

endmodule

// File: tb/tb_dmac_burst_ctrl.sv
// tb/tb_dmac_burst_ctrl.sv - randomized scoreboard bench for dmac_burst_ctrl
module tb_dmac_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] src_addr_i = '0;
    logic [31:0] dst_addr_i = '0;
    logic [15:0] byte_len_i = '0;
    logic        busy_o, done_o;
    logic [31:0] araddr_o, awaddr_o, wdata_o, fifo_wdata_o;
    logic [3:0]  arlen_o, awlen_o;
    logic        arvalid_o, rready_o, awvalid_o, wvalid_o, wlast_o, bready_o;
    logic        fifo_wren_o, fifo_rden_o;
    logic        arready_i = 1'b0, awready_i = 1'b0, wready_i = 1'b0;
    logic        rvalid_i = 1'b0, rlast_i = 1'b0, bvalid_i = 1'b0;
    logic [31:0] rdata_i = '0, fifo_rdata_i = '0;
    logic        fifo_full_i = 1'b0, fifo_empty_i = 1'b1;

    always #5 clk = ~clk;

    dmac_burst_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .byte_len_i(byte_len_i),
        .busy_o(busy_o), .done_o(done_o),
        .araddr_o(araddr_o), .arlen_o(arlen_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bvalid_i(bvalid_i), .bready_o(bready_o),
        .fifo_wren_o(fifo_wren_o), .fifo_wdata_o(fifo_wdata_o), .fifo_full_i(fifo_full_i),
        .fifo_rden_o(fifo_rden_o), .fifo_rdata_i(fifo_rdata_i), .fifo_empty_i(fifo_empty_i)
    );

    wire [9:0] ctrl_vec = {busy_o, done_o, arvalid_o, rready_o, awvalid_o, wvalid_o,
                           wlast_o, bready_o, fifo_wren_o, fifo_rden_o};
    wire       data_any = |{araddr_o, arlen_o, awaddr_o, awlen_o, wdata_o, fifo_wdata_o};

    typedef struct { logic [31:0] addr; logic [3:0] len; } addr_exp_t;
    typedef struct { logic [31:0] data; logic last; } w_exp_t;
    typedef struct { logic [31:0] addr; int beats; } rd_burst_t;

    addr_exp_t exp_ar[$];
    addr_exp_t exp_aw[$];
    w_exp_t    exp_w[$];
    int        exp_done = 0;
    int        n_checks = 0;
    int        n_fail   = 0;
    int        n_wbeats = 0;
    int        stall_pct = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h3C5A0F96;
    endfunction

    function automatic bit go();
        return $urandom_range(0, 99) >= stall_pct;
    endfunction

    // Reference model: whole-transfer view, split into bursts of at most 16 words.
    task automatic expect_transfer(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len);
        int          words = int'(len) / 4;
        logic [31:0] s = src;
        logic [31:0] d = dst;
        addr_exp_t   a;
        w_exp_t      w;
        while (words > 0) begin
            int b = (words > 16) ? 16 : words;
            a.addr = s; a.len = 4'(b - 1); exp_ar.push_back(a);
            a.addr = d;                    exp_aw.push_back(a);
            for (int i = 0; i < b; i++) begin
                w.data = mem_word(s + 32'(4 * i));
                w.last = (i == b - 1);
                exp_w.push_back(w);
            end
            s += 32'(4 * b);
            d += 32'(4 * b);
            words -= b;
        end
        exp_done++;
    endtask

    // Slave side: AXI memory, write sink and the FIFO, updated once per cycle.
    logic [31:0] fifo_q[$];
    rd_burst_t   rd_q[$];
    int          rd_idx = 0, b_pending = 0;
    bit          s_r, s_w, s_wlast, s_b, s_push, s_pop;
    logic [31:0] s_push_data;
    rd_burst_t   nb;

    initial begin : slave
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                fifo_q.delete(); rd_q.delete();
                rd_idx = 0; b_pending = 0;
            end else begin
                if (s_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
                if (s_push) fifo_q.push_back(s_push_data);
                if (s_r && rd_q.size() != 0) begin
                    rd_idx++;
                    if (rd_idx == rd_q[0].beats) begin void'(rd_q.pop_front()); rd_idx = 0; end
                end
                if (s_w && s_wlast) b_pending++;
                if (s_b) b_pending--;
            end
            arready_i = go();
            awready_i = go();
            wready_i  = go();
            if (!rst_n) rvalid_i = 1'b0;
            else if (!(rvalid_i && !s_r)) rvalid_i = (rd_q.size() != 0) && go();
            if (rd_q.size() != 0) begin
                rdata_i = mem_word(rd_q[0].addr + 32'(4 * rd_idx));
                rlast_i = (rd_idx == rd_q[0].beats - 1);
            end else begin
                rdata_i = '0; rlast_i = 1'b0;
            end
            if (!rst_n) bvalid_i = 1'b0;
            else if (!(bvalid_i && !s_b)) bvalid_i = (b_pending > 0) && go();
            fifo_full_i  = (fifo_q.size() >= 16);
            fifo_empty_i = (fifo_q.size() == 0);
            fifo_rdata_i = (fifo_q.size() != 0) ? fifo_q[0] : '0;
            #4;
            if (rst_n && arvalid_o && arready_i) begin
                nb.addr = araddr_o; nb.beats = int'(arlen_o) + 1;
                rd_q.push_back(nb);
            end
            s_r         = rst_n && rvalid_i && rready_o;
            s_w         = rst_n && wvalid_o && wready_i;
            s_wlast     = wlast_o;
            s_b         = rst_n && bvalid_i && bready_o;
            s_push      = rst_n && fifo_wren_o;
            s_push_data = fifo_wdata_o;
            s_pop       = rst_n && fifo_rden_o;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a handshake.
    bit          ar_wait = 0, aw_wait = 0;
    logic [35:0] ar_hold, aw_hold;
    addr_exp_t   ea;
    w_exp_t      ew;

    initial begin : monitor
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                ar_wait = 0; aw_wait = 0;
            end else begin
                if (ar_wait) check("ar_stable", {arvalid_o, arlen_o, araddr_o}, {1'b1, ar_hold});
                if (arvalid_o && arready_i) begin
                    check("ar_expected", exp_ar.size() != 0, 1);
                    if (exp_ar.size() != 0) begin
                        ea = exp_ar.pop_front();
                        check("ar_addr", araddr_o, ea.addr);
                        check("ar_len", arlen_o, ea.len);
                    end
                end
                ar_wait = arvalid_o && !arready_i;
                ar_hold = {arlen_o, araddr_o};
                if (aw_wait) check("aw_stable", {awvalid_o, awlen_o, awaddr_o}, {1'b1, aw_hold});
                if (awvalid_o && awready_i) begin
                    check("aw_expected", exp_aw.size() != 0, 1);
                    if (exp_aw.size() != 0) begin
                        ea = exp_aw.pop_front();
                        check("aw_addr", awaddr_o, ea.addr);
                        check("aw_len", awlen_o, ea.len);
                    end
                end
                aw_wait = awvalid_o && !awready_i;
                aw_hold = {awlen_o, awaddr_o};
                if (wvalid_o && wready_i) begin
                    n_wbeats++;
                    check("w_expected", exp_w.size() != 0, 1);
                    if (exp_w.size() != 0) begin
                        ew = exp_w.pop_front();
                        check("w_data", wdata_o, ew.data);
                        check("w_last", wlast_o, ew.last);
                    end
                end
                if (fifo_wren_o) check("fifo_push_not_full", fifo_full_i, 0);
                if (fifo_rden_o) check("fifo_pop_not_empty", fifo_empty_i, 0);
                if (done_o) begin
                    check("done_expected", exp_done != 0, 1);
                    check("done_busy_low", busy_o, 0);
                    if (exp_done != 0) exp_done--;
                end
            end
        end
    end

    task automatic flush_sb();
        exp_ar.delete(); exp_aw.delete(); exp_w.delete();
        exp_done = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        flush_sb();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (exp_done != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_within_budget", exp_done == 0, 1);
        check("scoreboard_drained", exp_ar.size() + exp_aw.size() + exp_w.size(), 0);
        if (exp_done != 0) apply_reset();
        repeat (3) @(negedge clk);
    endtask

    task automatic issue_start(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len);
        @(negedge clk);
        src_addr_i = src; dst_addr_i = dst; byte_len_i = len; start_i = 1'b1;
        expect_transfer(src, dst, len);
        @(negedge clk);
        start_i = 1'b0;
        #1;
        check("busy_after_start", busy_o, (len >> 2) != 0);
    endtask

    task automatic run_transfer(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len,
                                input int budget);
        issue_start(src, dst, len);
        wait_idle(budget);
    endtask

    int base;
    int n;

    initial begin : main
        repeat (3) @(negedge clk);
        #1;
        check("reset_ctrl", ctrl_vec, 0);
        check("reset_data", data_any, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #4;
            check("idle_ctrl", ctrl_vec, 0);
            check("idle_data", data_any, 0);
        end

        run_transfer(32'h0000_0000, 32'h0000_0000, 16'd0, 3);
        run_transfer(32'h0000_0100, 32'h0000_0200, 16'd3, 3);
        run_transfer(32'h0000_1000, 32'h0000_2000, 16'd64, 400);
        run_transfer(32'h0000_1000, 32'h0000_2000, 16'd200, 800);

        stall_pct = 50;
        run_transfer(32'h0000_3000, 32'h0000_4000, 16'd128, 3000);

        stall_pct = 30;
        issue_start(32'h0000_5000, 32'h0000_6000, 16'd160);
        repeat (12) @(negedge clk);
        src_addr_i = 32'h0000_9000; dst_addr_i = 32'h0000_9800; byte_len_i = 16'd64; start_i = 1'b1;
        #1;
        check("busy_at_second_start", busy_o, 1);
        @(negedge clk);
        start_i = 1'b0;
        wait_idle(4000);

        for (int k = 0; k < 5; k++) begin
            stall_pct = $urandom_range(0, 60);
            run_transfer($urandom() & 32'hFFFF_FFFC, $urandom() & 32'hFFFF_FFFC,
                         16'($urandom_range(0, 400)), 6000);
        end

        stall_pct = 0;
        base = n_wbeats;
        issue_start(32'h0000_7000, 32'h0000_8000, 16'd64);
        n = 0;
        while (n_wbeats - base < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("beats_before_reset", n_wbeats - base, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_ctrl", ctrl_vec, 0);
        check("async_reset_data", data_any, 0);
        flush_sb();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #4;
        check("post_reset_idle", ctrl_vec, 0);
        run_transfer(32'h0000_A000, 32'h0000_B000, 16'd16, 400);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
